// File: rtl/io_bridge.sv
// io_bridge: memory-mapped responder between the CPU data bus and board I/O.
// Decodes Bus_addr into DRAM or the peripheral page (0xFFFFF000..0xFFFFFFFF).
// The peripheral page holds LEDs, switches, buttons, an 8-digit seven-segment
// scanner and an optional millisecond timer.
// Optional feature macro: BRIDGE_TIMER_EN builds the TIMER register at offset
// 0x020. Without it, that offset reads 0 and ignores writes.
module io_bridge #(
    parameter int unsigned DRAM_AW  = 14,
    parameter int unsigned SCAN_DIV = 20000,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Word offsets within the peripheral page (byte offset >> 2)
    localparam logic [9:0] OffDig   = 10'h000;
    localparam logic [9:0] OffTimer = 10'h008;
    localparam logic [9:0] OffLed   = 10'h018;
    localparam logic [9:0] OffSw    = 10'h01C;
    localparam logic [9:0] OffBtn   = 10'h01E;

    // Active-low seven-segment code, dp kept off
    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    logic        w_periph;
    logic [9:0]  w_word;
    logic        w_dig_we;
    logic        w_led_we;
    logic [31:0] w_timer_rd;
    logic        w_unused_addr;

    logic [31:0]       r_dig;
    logic [23:0]       r_led;
    logic [23:0]       r_sw_meta;
    logic [23:0]       r_sw_sync;
    logic [4:0]        r_btn_meta;
    logic [4:0]        r_btn_sync;
    logic [ScanW-1:0]  r_scan_cnt;
    logic [2:0]        r_digit;
    logic [7:0]        r_dig_en;
    logic [7:0]        r_seg;

    assign w_periph      = (Bus_addr[31:12] == 20'hFFFFF);
    assign w_word        = Bus_addr[11:2];
    assign w_dig_we      = Bus_wen & w_periph & (w_word == OffDig);
    assign w_led_we      = Bus_wen & w_periph & (w_word == OffLed);
    // Byte lane bits are irrelevant to a word-only bus
    assign w_unused_addr = ^Bus_addr[1:0];

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_wen & ~w_periph;
    assign dram_wdata = Bus_wdata;

    assign led    = r_led;
    assign dig_en = r_dig_en;
    assign seg    = r_seg;

    // Writable peripheral registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dig <= '0;
            r_led <= '0;
        end else begin
            if (w_dig_we) r_dig <= Bus_wdata;
            if (w_led_we) r_led <= Bus_wdata[23:0];
        end
    end

    // Two-flop synchronizers for the asynchronous switch and button inputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Display scan: prescaler advances the digit index, outputs re-registered every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_dig_en   <= 8'hFE;
            r_seg      <= 8'hC0;
        end else begin
            if (r_scan_cnt == ScanW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + ScanW'(1);
            end
            r_dig_en <= ~(8'b1 << r_digit);
            r_seg    <= hex7(r_dig[{r_digit, 2'b00} +: 4]);
        end
    end

`ifdef BRIDGE_TIMER_EN
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic             w_timer_we;
    logic [TickW-1:0] r_tick_cnt;
    logic [31:0]      r_timer;

    assign w_timer_we = Bus_wen & w_periph & (w_word == OffTimer);
    assign w_timer_rd = r_timer;

    // Millisecond timer; a bus write beats a same-cycle tick and restarts the prescaler
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_timer    <= '0;
        end else if (w_timer_we) begin
            r_tick_cnt <= '0;
            r_timer    <= Bus_wdata;
        end else if (r_tick_cnt == TickW'(TICK_DIV - 1)) begin
            r_tick_cnt <= '0;
            r_timer    <= r_timer + 32'd1;
        end else begin
            r_tick_cnt <= r_tick_cnt + TickW'(1);
        end
    end
`else
    assign w_timer_rd = '0;
`endif

    // Combinational read mux: the CPU samples read data in the address cycle
    always_comb begin
        Bus_rdata = '0;
        if (!w_periph) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (w_word)
                OffDig:   Bus_rdata = r_dig;
                OffTimer: Bus_rdata = w_timer_rd;
                OffLed:   Bus_rdata = {8'h00, r_led};
                OffSw:    Bus_rdata = {8'h00, r_sw_sync};
                OffBtn:   Bus_rdata = {27'h0, r_btn_sync};
                default:  Bus_rdata = '0;
            endcase
        end
    end

endmodule
